// File: rtl/arb_rr_4_if.sv
// Request/grant bundle between four masters and the round-robin arbiter.
// The master side drives requests and release; the slave (arbiter) side drives grants.
interface arb_rr_4_if;
  logic [3:0] req;
  logic       done;
  logic [1:0] gnt_idx;
  logic       gnt_en;
  logic [3:0] gnt;
  logic       preempt;

  modport master (
    output req,
    output done,
    input  gnt_idx,
    input  gnt_en,
    input  gnt,
    input  preempt
  );

  modport slave (
    input  req,
    input  done,
    output gnt_idx,
    output gnt_en,
    output gnt,
    output preempt
  );
endinterface

// File: rtl/arb_rr_4.sv
// Four-requester round-robin arbiter with hold/release handshake and optional hold limit.
//   state | meaning
//   IDLE  | no owner; arbitrate from last+1 when any request is pending
//   GRANT | one owner holds the resource until done, request drop, or hold limit
module arb_rr_4 #(
  parameter int HOLD_MAX = 0
) (
  input  logic        clk,
  input  logic        rst,
  arb_rr_4_if.slave   bus
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [7:0] HOLD_LAST = (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);

  state_e     state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [1:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_en_q, gnt_en_d;
  logic [3:0] gnt_q, gnt_d;
  logic       preempt_q, preempt_d;
  logic [7:0] cnt_q, cnt_d;

  logic [1:0] win;
  logic       win_vld;
  logic [1:0] cand;
  logic       rel_done, rel_drop, rel_lim;

  // Scan starts just past the previous winner, so a released owner ranks last.
  always_comb begin
    win     = 2'd0;
    win_vld = 1'b0;
    cand    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = last_q + 2'd1 + 2'(k);
      if (!win_vld && bus.req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  assign rel_done = bus.done;
  assign rel_drop = !bus.req[gnt_idx_q];
  assign rel_lim  = (HOLD_MAX != 0) && (cnt_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_idx_d = gnt_idx_q;
    gnt_en_d  = gnt_en_q;
    gnt_d     = gnt_q;
    preempt_d = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        gnt_en_d = 1'b0;
        gnt_d    = 4'b0000;
        if (win_vld) begin
          state_d   = GRANT;
          gnt_idx_d = win;
          gnt_en_d  = 1'b1;
          gnt_d     = 4'b0001 << win;
          last_d    = win;
          cnt_d     = 8'd0;
        end
      end
      GRANT: begin
        if (cnt_q != 8'hff) cnt_d = cnt_q + 8'd1;
        if (rel_done || rel_drop || rel_lim) begin
          state_d   = IDLE;
          gnt_en_d  = 1'b0;
          gnt_d     = 4'b0000;
          preempt_d = rel_lim && !rel_done && !rel_drop;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 2'd3;
      gnt_idx_q <= 2'd0;
      gnt_en_q  <= 1'b0;
      gnt_q     <= 4'b0000;
      preempt_q <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_en_q  <= gnt_en_d;
      gnt_q     <= gnt_d;
      preempt_q <= preempt_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.gnt_idx = gnt_idx_q;
  assign bus.gnt_en  = gnt_en_q;
  assign bus.gnt     = gnt_q;
  assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_arb_rr_4.sv
// Bench for arb_rr_4: three instances (unlimited, limit 4, limit 1) share one stimulus
// stream and are compared every cycle against a tenure-level reference model.
module tb_arb_rr_4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;

  int n_chk;
  int n_fail;

  // Reference model state per instance: owner is -1 when nobody holds the grant,
  // held counts granted cycles of the current tenure including the present one.
  int m_owner [3];
  int m_last  [3];
  int m_held  [3];
  int m_idx   [3];
  int m_pre   [3];

  arb_rr_4_if bus0();
  arb_rr_4_if bus1();
  arb_rr_4_if bus2();

  assign bus0.req = req;  assign bus0.done = done;
  assign bus1.req = req;  assign bus1.done = done;
  assign bus2.req = req;  assign bus2.done = done;

  arb_rr_4 #(.HOLD_MAX(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  arb_rr_4 #(.HOLD_MAX(4)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  arb_rr_4 #(.HOLD_MAX(1)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int hmax(input int d);
    case (d)
      1:       return 4;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_update(input int d);
    int h;
    bit lim, own_req;
    h = hmax(d);
    if (rst) begin
      m_owner[d] = -1; m_last[d] = 3; m_held[d] = 0; m_idx[d] = 0; m_pre[d] = 0;
    end else if (m_owner[d] < 0) begin
      m_pre[d] = 0;
      if (req != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          if (m_owner[d] < 0 && req[(m_last[d] + k) % 4]) m_owner[d] = (m_last[d] + k) % 4;
        end
        m_idx[d]  = m_owner[d];
        m_last[d] = m_owner[d];
        m_held[d] = 1;
      end
    end else begin
      own_req = req[m_owner[d]];
      lim     = (h != 0) && (m_held[d] >= h);
      m_pre[d] = 0;
      if (done || !own_req || lim) begin
        m_pre[d]   = (lim && !done && own_req) ? 1 : 0;
        m_owner[d] = -1;
      end else begin
        m_held[d]++;
      end
    end
  endtask

  task automatic cmp_dut(input int d, input logic [1:0] idx, input logic en,
                         input logic [3:0] g, input logic p);
    logic [3:0] exp_g;
    exp_g = (m_owner[d] >= 0) ? (4'b0001 << m_idx[d]) : 4'b0000;
    chk($sformatf("d%0d.gnt_idx", d), 32'(idx), 32'(m_idx[d]));
    chk($sformatf("d%0d.gnt_en", d),  32'(en),  32'(m_owner[d] >= 0));
    chk($sformatf("d%0d.gnt", d),     32'(g),   32'(exp_g));
    chk($sformatf("d%0d.preempt", d), 32'(p),   32'(m_pre[d]));
  endtask

  task automatic step();
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_update(d);
    #1;
    cmp_dut(0, bus0.gnt_idx, bus0.gnt_en, bus0.gnt, bus0.preempt);
    cmp_dut(1, bus1.gnt_idx, bus1.gnt_en, bus1.gnt, bus1.preempt);
    cmp_dut(2, bus2.gnt_idx, bus2.gnt_en, bus2.gnt, bus2.preempt);
  endtask

  task automatic cyc(input logic [3:0] r, input logic dn, input logic rs);
    req  = r;
    done = dn;
    rst  = rs;
    step();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst  = 1'b1;
    req  = 4'b1111;
    done = 1'b1;
    for (int d = 0; d < 3; d++) begin
      m_owner[d] = -1; m_last[d] = 3; m_held[d] = 0; m_idx[d] = 0; m_pre[d] = 0;
    end

    // Reset held with every input active
    cyc(4'b1111, 1'b1, 1'b1);
    cyc(4'b1111, 1'b1, 1'b1);
    cyc(4'b1111, 1'b0, 1'b0);
    chk("first_gnt", 32'(bus0.gnt), 32'h1);

    // Round robin: owner releases one cycle after each grant
    for (int i = 0; i < 14; i++) cyc(4'b1111, (m_owner[0] >= 0), 1'b0);

    // Single requester, release on the third granted cycle
    cyc(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) cyc(4'b0100, (m_owner[0] >= 0 && m_held[0] == 3), 1'b0);

    // Sparse requests with the owner dropping its request
    cyc(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(4'b1010, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(4'b1000, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(4'b1010, 1'b0, 1'b0);

    // Hold limit without done, then with done landing on the limit cycle of the limited instance
    cyc(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cyc(4'b0011, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(4'b0011, (m_owner[1] >= 0 && m_held[1] == 4), 1'b0);

    // Reset in the middle of a tenure
    cyc(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b1);
    cyc(4'b0101, 1'b0, 1'b0);
    chk("post_rst_gnt", 32'(bus0.gnt), 32'h1);
    for (int i = 0; i < 6; i++) cyc(4'b0101, 1'b0, 1'b0);

    // Randomized traffic: sticky requests, occasional release and reset
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] r;
      r = req;
      for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) r[b] = ~r[b];
      cyc(r, ($urandom_range(5) == 0), ($urandom_range(199) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
